// File: rtl/ula.sv
// ula: registered ALU with one-cycle latency and a registered Zero flag.
// Define ULA_OVERFLOW_EN to add a registered signed-overflow output for ADD/SUB.
module ula #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
`ifdef ULA_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);
    localparam logic [3:0] OP_SUB = 4'b0000, OP_ADD = 4'b0001, OP_AND = 4'b0010,
                           OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLT = 4'b0101,
                           OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SLTU = 4'b1000,
                           OP_SRA = 4'b1001;
    logic [WIDTH-1:0] sum, diff, res;
    logic [4:0]       shamt;
    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[4:0];
    always_comb begin
        res = '0;
        case (ALUControl)
            OP_SUB:  res = diff;
            OP_ADD:  res = sum;
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_SLT:  res = WIDTH'($signed(A) < $signed(B));
            OP_SLL:  res = A << shamt;
            OP_SRL:  res = A >> shamt;
            OP_SLTU: res = WIDTH'(A < B);
            OP_SRA:  res = WIDTH'($signed(A) >>> shamt);
            default: res = '0;
        endcase
    end
`ifdef ULA_OVERFLOW_EN
    // Overflow when the operands (B inverted for SUB) agree in sign but the result does not.
    logic ovf;
    assign ovf = (ALUControl == OP_ADD) ? (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]) :
                 (ALUControl == OP_SUB) ? (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]) :
                 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
`ifdef ULA_OVERFLOW_EN
            Overflow  <= 1'b0;
`endif
        end else begin
            ALUResult <= res;
            Zero      <= (res == '0);
`ifdef ULA_OVERFLOW_EN
            Overflow  <= ovf;
`endif
        end
    end
endmodule

// File: tb/tb_ula.sv
// tb_ula: directed scoreboard bench for ula; expectations are queued on drive and checked one edge later.
module tb_ula;
    localparam int W = 32;
    localparam logic [3:0] SUB = 4'b0000, ADD = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           XOR_ = 4'b0100, SLT = 4'b0101, SLL = 4'b0110, SRL = 4'b0111,
                           SLTU = 4'b1000, SRA = 4'b1001;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ALUControl = 4'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] ALUResult;
    logic         Zero;
`ifdef ULA_OVERFLOW_EN
    logic         Overflow;
`endif
    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
    } exp_t;
    exp_t  q[$];
    string tq[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ula #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ALUControl(ALUControl), .A(A), .B(B),
        .ALUResult(ALUResult), .Zero(Zero)
`ifdef ULA_OVERFLOW_EN
        , .Overflow(Overflow)
`endif
    );

    task automatic check_w(string tag, logic [W-1:0] got, logic [W-1:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_b(string tag, logic got, logic want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic drive(string tag, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] r, logic z, logic o = 1'b0);
        ALUControl = c;
        A = a;
        B = b;
        q.push_back('{res: r, z: z, ovf: o});
        tq.push_back(tag);
    endtask

    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = q.pop_front();
            t = tq.pop_front();
            check_w({t, ".res"}, ALUResult, e.res);
            check_b({t, ".zero"}, Zero, e.z);
`ifdef ULA_OVERFLOW_EN
            check_b({t, ".ovf"}, Overflow, e.ovf);
`endif
        end
    endtask

    initial begin
        // Reset held for two edges while an ADD is presented: reset must win.
        rst = 1'b1;
        drive("rst0", ADD, 5, 3, 0, 1'b1);
        tick();
        drive("rst1", ADD, 5, 3, 0, 1'b1);
        tick();
        rst = 1'b0;
        drive("first_add", ADD, 5, 3, 8, 1'b0);
        tick();
        rst = 1'b1;
        drive("rst_mid", ADD, 5, 3, 0, 1'b1);
        tick();
        rst = 1'b0;
        drive("sub_b0", SUB, 213, 0, 213, 1'b0);
        tick();
        drive("sub_eq", SUB, 213, 213, 0, 1'b1);
        tick();
        drive("sub_60", SUB, 213, 60, 153, 1'b0);
        tick();
        drive("sub_wrap", SUB, 0, 1, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive("add", ADD, 213, 60, 273, 1'b0);
        tick();
        drive("add_wrap", ADD, 32'hFFFF_FFFF, 1, 0, 1'b1);
        tick();
        drive("and", AND_, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        tick();
        drive("or", OR_, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        tick();
        drive("xor", XOR_, 32'hFF, 32'h0F, 32'hF0, 1'b0);
        tick();
        drive("slt", SLT, 1, 2, 1, 1'b0);
        tick();
        drive("slt_neg", SLT, 32'hFFFF_FFFF, 1, 1, 1'b0);
        tick();
        drive("sltu_big", SLTU, 32'hFFFF_FFFF, 1, 0, 1'b1);
        tick();
        drive("sltu_gt", SLTU, 1917, 960, 0, 1'b1);
        tick();
        drive("sltu_eq", SLTU, 960, 960, 0, 1'b1);
        tick();
        drive("sltu_lt", SLTU, 960, 1917, 1, 1'b0);
        tick();
        drive("sll", SLL, 4, 1, 8, 1'b0);
        tick();
        drive("srl_out", SRL, 213, 9, 0, 1'b1);
        tick();
        drive("srl_31", SRL, 32'h8000_0000, 31, 1, 1'b0);
        tick();
        drive("sra_31", SRA, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive("sll_b5", SLL, 1, 32'h21, 2, 1'b0);
        tick();
        drive("sra_0", SRA, 32'h8000_00F0, 0, 32'h8000_00F0, 1'b0);
        tick();
        // Back-to-back: the AND is applied right after the ADD edge; outputs must not move until the next edge.
        drive("b2b_add", ADD, 100, 23, 123, 1'b0);
        tick();
        drive("b2b_and", AND_, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0);
        #1;
        check_w("b2b_hold", ALUResult, 123);
        tick();
        drive("code_f", 4'b1111, 32'h1234, 32'h5678, 0, 1'b1);
        tick();
        drive("code_a", 4'b1010, 32'hFFFF, 32'h1, 0, 1'b1);
        tick();
        drive("add_ovf", ADD, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1'b0, 1'b1);
        tick();
        drive("sub_ovf", SUB, 32'h8000_0000, 1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        tick();
        drive("xor_noovf", XOR_, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFE, 1'b0, 1'b0);
        tick();
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL drain: observed %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ula.md
ULA -- requirements
Module: ula

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, meaning the data-path width of A, B and ALUResult.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ALUControl  input  4  operation select.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand; for shifts, B[4:0] is the shift amount.
REQ-008 ALUResult  output  WIDTH  registered operation result.
REQ-009 Zero  output  1  registered flag: 1 when ALUResult is all zeros.

Function
REQ-010 The block SHALL sample ALUControl, A and B on every rising clk edge and present ALUResult and Zero after that edge: latency 1 cycle, throughput 1 operation per cycle, no handshake.
REQ-011 Outputs SHALL hold their value between edges; A, B and ALUControl SHALL have no combinational path to any output.
REQ-012 The ALUControl encoding SHALL be:
- 0000 SUB: A-B
- 0001 ADD: A+B
- 0010 AND: A&B
- 0011 OR: A|B
- 0100 XOR: A^B
- 0101 SLT: 1 if signed A < signed B, else 0
- 0110 SLL: A << B[4:0]
- 0111 SRL: A >> B[4:0], logical (zero fill)
- 1000 SLTU: 1 if unsigned A < unsigned B, else 0
- 1001 SRA: A >>> B[4:0], arithmetic (sign fill)
REQ-013 ADD and SUB SHALL wrap modulo 2^WIDTH; carry-out and borrow SHALL be discarded.
REQ-014 SLT and SLTU SHALL zero-extend the 1-bit result to WIDTH.
REQ-015 Shifts SHALL use only B[4:0], with B[WIDTH-1:5] ignored; a shift amount of 0 SHALL return A unchanged.
REQ-016 Codes 1010-1111 SHALL produce ALUResult = 0 and Zero = 1.
REQ-017 Zero SHALL be computed from the same-cycle result, so Zero and ALUResult always correspond to the same operation.

Reset
REQ-018 While rst is high at a rising clk edge, ALUResult SHALL become 0 and Zero SHALL become 1.
REQ-019 Reset SHALL take priority over any operation sampled on the same edge.
REQ-020 The first valid result after reset release SHALL appear one edge after the first edge with rst low.

Configuration
REQ-021 Macro ULA_OVERFLOW_EN: when defined, the block SHALL add output Overflow (1 bit, registered, reset value 0).
REQ-022 With ULA_OVERFLOW_EN defined, Overflow SHALL equal signed two's-complement overflow for ADD and SUB, and SHALL be 0 for every other code.
REQ-023 When ULA_OVERFLOW_EN is not defined, the Overflow port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-024 Reset: rst=1 for 2 edges -> ALUResult=0, Zero=1; rst=1 mid-stream (ADD 5+3 active) -> next edge gives 0 and 1.
REQ-025 SUB, all with ALUControl=0000 and A=213:
- B=0 -> 213, Zero=0
- B=213 -> 0, Zero=1
- B=60 -> 153
- A=0, B=1 -> 0xFFFFFFFF
REQ-026 Arithmetic and logic:
- ADD 213+60 -> 273
- ADD 0xFFFFFFFF+1 -> 0, Zero=1
- AND 0xFF,0x0F -> 0x0F
- OR 0xF0,0x0F -> 0xFF
- XOR 0xFF,0x0F -> 0xF0
REQ-027 Compares:
- SLT 1,2 -> 1
- SLT 0xFFFFFFFF,1 -> 1
- SLTU 0xFFFFFFFF,1 -> 0
- SLTU 1917,960 -> 0, Zero=1
- SLTU 960,960 -> 0, Zero=1
REQ-028 Shifts:
- SLL 4,1 -> 8
- SRL 213,9 -> 0, Zero=1
- SRL 0x80000000,31 -> 1
- SRA 0x80000000,31 -> 0xFFFFFFFF
- SLL 1,B=0x21 -> 2 (only B[4:0] used)
REQ-029 Latency and configuration:
- back-to-back ADD then AND on consecutive edges -> each result appears exactly one edge later
- code 1111 -> ALUResult=0, Zero=1
- with ULA_OVERFLOW_EN, ADD 0x7FFFFFFF+1 -> Overflow=1
